pipelined_barrel_shifter: RTL

Parametrised, fully pipelined barrel shifter. Supports four shift modes and a valid/ready handshake on both sides.
- One log2 stage per pipeline register.
- Accepts one operand per cycle and tolerates downstream back-pressure.
- Successor to the combinational 8-bit switch/button shifter. Sits between an operand source (switch/UART/ALU front-end) and a consumer such as an LED/display driver or an ALU result bus.

---
 rtl/pipelined_barrel_shifter_pkg.sv | 11 +
 rtl/shift_pipe_stage.sv | 68 ++++++
 rtl/pipelined_barrel_shifter.sv | 66 ++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encoding.
package pipelined_barrel_shifter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LSL = 2'b00;
  localparam mode_t MODE_LSR = 2'b01;
  localparam mode_t MODE_ASR = 2'b10;
  localparam mode_t MODE_ROR = 2'b11;

endpackage

// File: rtl/shift_pipe_stage.sv
// One log2 stage of the barrel shifter: conditional shift by 2**STAGE, then a
// valid/ready pipeline register carrying data, amount and mode.
module shift_pipe_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH),
  parameter int unsigned STAGE = 0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  mode_t            mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AMT_W-1:0] amt_o,
  output mode_t            mode_o
);

  localparam int unsigned Shift = 2 ** STAGE;

  logic [WIDTH-1:0] shifted;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] amt_q;
  mode_t            mode_q;

  always_comb begin
    shifted = data_i;
    if (amt_i[STAGE]) begin
      unique case (mode_i)
        MODE_LSL: shifted = data_i << Shift;
        MODE_LSR: shifted = data_i >> Shift;
        // Earlier ASR stages never alter the MSB, so data_i still holds the sign.
        MODE_ASR: shifted = $signed(data_i) >>> Shift;
        MODE_ROR: shifted = (data_i >> Shift) | (data_i << (WIDTH - Shift));
      endcase
    end
  end

  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= shifted;
        amt_q  <= amt_i;
        mode_q <= mode_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter (LSL/LSR/ASR/ROR), one log2 stage per register,
// with valid/ready handshakes and combinational back-pressure chaining.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Index k is the input of stage k; index AMT_W is the final register.
  logic             valid_c [AMT_W+1];
  logic             ready_c [AMT_W+1];
  logic [WIDTH-1:0] data_c  [AMT_W+1];
  logic [AMT_W-1:0] amt_c   [AMT_W+1];
  mode_t            mode_c  [AMT_W+1];

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign amt_c[0]   = in_amt;
  assign mode_c[0]  = in_mode;
  assign in_ready   = ready_c[0];

  assign ready_c[AMT_W] = !valid_c[AMT_W] || out_ready;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    shift_pipe_stage #(
      .WIDTH(WIDTH),
      .AMT_W(AMT_W),
      .STAGE(k)
    ) u_stage (
      .clk_i   (clk),
      .reset_ni(reset_n),
      .valid_i (valid_c[k]),
      .ready_o (ready_c[k]),
      .data_i  (data_c[k]),
      .amt_i   (amt_c[k]),
      .mode_i  (mode_c[k]),
      .valid_o (valid_c[k+1]),
      .ready_i (ready_c[k+1]),
      .data_o  (data_c[k+1]),
      .amt_o   (amt_c[k+1]),
      .mode_o  (mode_c[k+1])
    );
  end

  assign out_valid = valid_c[AMT_W];
  assign out_data  = data_c[AMT_W];
  // Gated by valid so the flag reads 0 out of reset even though data is 0.
  assign out_zero  = valid_c[AMT_W] && (data_c[AMT_W] == '0);

  logic unused_tail;
  assign unused_tail = ^{amt_c[AMT_W], mode_c[AMT_W]};

endmodule
